// File: rtl/fft_sdf_stage.sv
// Radix-2 single-delay-feedback butterfly stage with optional trivial +/-j rotation,
// per-stage round-half-up scaling or saturation, and a sticky overflow flag.
module fft_sdf_stage #(
    parameter int FFT_STG     = 7,
    parameter int REAL_WIDTH  = 18,
    parameter int IMGN_WIDTH  = 18,
    parameter int TOTAL_STAGE = 11,
    parameter int ROT_EN      = 0,
    parameter int ROT_BIT     = 0,
    localparam int CPLX_WIDTH = REAL_WIDTH + IMGN_WIDTH
) (
    input  logic                   iclk,
    input  logic                   rst_n,
    input  logic                   iclr,
    input  logic                   iinv,
    input  logic                   iscale,
    input  logic                   ien,
    input  logic [CPLX_WIDTH-1:0]  idata,
    input  logic [TOTAL_STAGE-1:0] iaddr,
    output logic                   oen,
    output logic [CPLX_WIDTH-1:0]  odata,
    output logic [TOTAL_STAGE-1:0] oaddr,
    output logic                   oovf
);
    localparam int DEPTH = 1 << (FFT_STG - 1);
    localparam int RW    = REAL_WIDTH;
    localparam int IW    = IMGN_WIDTH;

    // Returns {ovf, result}; v is a width+1 sum/difference.
    function automatic logic [RW:0] fit_re(input logic [RW:0] v, input logic scale);
        logic [RW:0] r;
        logic [RW:0] res;
        r = v + {{RW{1'b0}}, 1'b1};
        if (scale) res = {1'b0, r[RW:1]};
        else if (v[RW] != v[RW-1]) res = {1'b1, v[RW], {(RW-1){~v[RW]}}};
        else res = {1'b0, v[RW-1:0]};
        return res;
    endfunction

    function automatic logic [IW:0] fit_im(input logic [IW:0] v, input logic scale);
        logic [IW:0] r;
        logic [IW:0] res;
        r = v + {{IW{1'b0}}, 1'b1};
        if (scale) res = {1'b0, r[IW:1]};
        else if (v[IW] != v[IW-1]) res = {1'b1, v[IW], {(IW-1){~v[IW]}}};
        else res = {1'b0, v[IW-1:0]};
        return res;
    endfunction

    // Negation with saturation of the most negative value; returns {ovf, result}.
    function automatic logic [RW:0] neg_re(input logic [RW-1:0] a);
        logic [RW:0] res;
        if (a == {1'b1, {(RW-1){1'b0}}}) res = {1'b1, 1'b0, {(RW-1){1'b1}}};
        else res = {1'b0, ~a + {{(RW-1){1'b0}}, 1'b1}};
        return res;
    endfunction

    function automatic logic [IW:0] neg_im(input logic [IW-1:0] a);
        logic [IW:0] res;
        if (a == {1'b1, {(IW-1){1'b0}}}) res = {1'b1, 1'b0, {(IW-1){1'b1}}};
        else res = {1'b0, ~a + {{(IW-1){1'b0}}, 1'b1}};
        return res;
    endfunction

    logic [CPLX_WIDTH-1:0]  dly_r [DEPTH];
    logic [CPLX_WIDTH-1:0]  d_s, din_s, dout_s;
    logic [RW-1:0]          d_re_s, x_re_s, b_as_re_s;
    logic [IW-1:0]          d_im_s, x_im_s, a_as_im_s;
    logic [RW:0]            sum_re_s, dif_re_s, fs_re_s, fd_re_s, nb_s;
    logic [IW:0]            sum_im_s, dif_im_s, fs_im_s, fd_im_s, na_s;
    logic [TOTAL_STAGE-1:0] oaddr_s;
    logic [FFT_STG-1:0]     local_s, ord_s, cnt_r;
    logic                   phase_s, rot_sel_s, ovf_s, accept_s;
    logic                   start_s, track_s, hit_s, started_r, primed_r;

    assign d_s       = dly_r[DEPTH-1];
    assign d_re_s    = d_s[CPLX_WIDTH-1:IW];
    assign d_im_s    = d_s[IW-1:0];
    assign x_re_s    = idata[CPLX_WIDTH-1:IW];
    assign x_im_s    = idata[IW-1:0];
    assign sum_re_s  = {d_re_s[RW-1], d_re_s} + {x_re_s[RW-1], x_re_s};
    assign dif_re_s  = {d_re_s[RW-1], d_re_s} - {x_re_s[RW-1], x_re_s};
    assign sum_im_s  = {d_im_s[IW-1], d_im_s} + {x_im_s[IW-1], x_im_s};
    assign dif_im_s  = {d_im_s[IW-1], d_im_s} - {x_im_s[IW-1], x_im_s};
    assign fs_re_s   = fit_re(sum_re_s, iscale);
    assign fd_re_s   = fit_re(dif_re_s, iscale);
    assign fs_im_s   = fit_im(sum_im_s, iscale);
    assign fd_im_s   = fit_im(dif_im_s, iscale);
    // Component swap for rotation sign-extends or truncates when widths differ.
    assign b_as_re_s = RW'($signed(d_im_s));
    assign a_as_im_s = IW'($signed(d_re_s));
    assign nb_s      = neg_re(b_as_re_s);
    assign na_s      = neg_im(a_as_im_s);

    assign phase_s   = iaddr[FFT_STG-1];
    assign oaddr_s   = iaddr - TOTAL_STAGE'(DEPTH);
    assign rot_sel_s = (ROT_EN != 0) && oaddr_s[ROT_BIT];
    assign accept_s  = ien & ~iclr;

    assign local_s   = iaddr[FFT_STG-1:0];
    assign start_s   = (local_s == {FFT_STG{1'b0}});
    assign track_s   = start_s | started_r;
    assign ord_s     = start_s ? {FFT_STG{1'b0}} : cnt_r;
    assign hit_s     = track_s && (ord_s == FFT_STG'(DEPTH - 1));

    // Butterfly datapath: select emitted value and delay-line input by phase.
    always_comb begin
        din_s  = idata;
        dout_s = d_s;
        ovf_s  = 1'b0;
        if (phase_s) begin
            dout_s = {fs_re_s[RW-1:0], fs_im_s[IW-1:0]};
            din_s  = {fd_re_s[RW-1:0], fd_im_s[IW-1:0]};
            ovf_s  = fs_re_s[RW] | fs_im_s[IW] | fd_re_s[RW] | fd_im_s[IW];
        end else if (rot_sel_s) begin
            if (iinv) begin
                dout_s = {nb_s[RW-1:0], a_as_im_s};
                ovf_s  = nb_s[RW];
            end else begin
                dout_s = {b_as_re_s, na_s[IW-1:0]};
                ovf_s  = na_s[IW];
            end
        end else begin
            dout_s = d_s;
            ovf_s  = 1'b0;
        end
    end

    // Feedback delay line; holds data only, so it is left unreset.
    always_ff @(posedge iclk) begin
        if (accept_s) begin
            dly_r[0] <= din_s;
            for (int i = 1; i < DEPTH; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    // Output registers, priming tracker and sticky overflow.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            oen       <= 1'b0;
            odata     <= {CPLX_WIDTH{1'b0}};
            oaddr     <= {TOTAL_STAGE{1'b0}};
            oovf      <= 1'b0;
            primed_r  <= 1'b0;
            started_r <= 1'b0;
            cnt_r     <= {FFT_STG{1'b0}};
        end else if (iclr) begin
            oen       <= 1'b0;
            oovf      <= 1'b0;
            primed_r  <= 1'b0;
            started_r <= 1'b0;
            cnt_r     <= {FFT_STG{1'b0}};
        end else if (ien) begin
            oen   <= primed_r;
            odata <= dout_s;
            oaddr <= oaddr_s;
            // Unprimed outputs carry stale delay-line data, so they never raise the flag.
            if (primed_r && ovf_s) oovf <= 1'b1;
            if (track_s) begin
                started_r <= 1'b1;
                if (!primed_r) cnt_r <= ord_s + FFT_STG'(1);
                if (hit_s) primed_r <= 1'b1;
            end
        end else begin
            oen <= 1'b0;
        end
    end
endmodule
